// File: rtl/eth_measurer_stats.sv
// Latency statistics and result-record FIFO placed after the measurer coordinator.
// Define ETH_MEASURER_STATS_TIMESTAMP_EN to prefix each record with a 64-bit cycle timestamp.
module eth_measurer_stats #(
  parameter int FIFO_DEPTH = 16,
`ifdef ETH_MEASURER_STATS_TIMESTAMP_EN
  localparam int RW = 128,
`else
  localparam int RW = 64,
`endif
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          done,
  input  logic [31:0]   ping_time,
  input  logic [31:0]   pong_time,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [RW-1:0] rd_data,
  output logic [LW-1:0] fifo_level,
  output logic [31:0]   fifo_overflows,
  output logic [63:0]   ping_count,
  output logic [31:0]   ping_min,
  output logic [31:0]   ping_max,
  output logic [63:0]   ping_sum,
  output logic [63:0]   pong_count,
  output logic [31:0]   pong_min,
  output logic [31:0]   pong_max,
  output logic [63:0]   pong_sum
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [31:0] LOST = 32'hFFFF_FFFF;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] level;
  logic [AW-1:0] rd_addr_inc;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [RW-1:0] rd_data_reg;
  logic [RW-1:0] rd_data_next;
  logic [RW-1:0] rec;
  logic [31:0]   ovf_reg;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          accept;
  logic          overflow;

`ifdef ETH_MEASURER_STATS_TIMESTAMP_EN
  logic [63:0] ts_reg;

  // Free-running; deliberately not affected by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_reg <= 64'd0;
    end else begin
      ts_reg <= ts_reg + 64'd1;
    end
  end

  assign rec = {ts_reg, ping_time, pong_time};
`else
  assign rec = {ping_time, pong_time};
`endif

  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push        = done && !clear;
  assign pop         = rd_en && !empty && !clear;
  assign accept      = push && (!full || pop);
  assign overflow    = push && full && !pop;
  assign rd_addr_inc = rd_ptr_reg[AW-1:0] + AW'(1);

  // Head register: loads the incoming record when it becomes the only entry,
  // otherwise the entry behind the one being popped; holds when draining to empty.
  always_comb begin
    rd_data_next = rd_data_reg;
    if (accept && (empty || (pop && level == PW'(1)))) begin
      rd_data_next = rec;
    end else if (pop && level != PW'(1)) begin
      rd_data_next = mem[rd_addr_inc];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg[AW-1:0]] <= rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      ovf_reg     <= '0;
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_data_next;
      if (clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        ovf_reg    <= '0;
      end else begin
        if (accept) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        if (overflow && ovf_reg != 32'hFFFF_FFFF) begin
          ovf_reg <= ovf_reg + 32'd1;
        end
      end
    end
  end

  logic [31:0] sample [2];
  assign sample[0] = ping_time;
  assign sample[1] = pong_time;

  // Channel 0 tracks ping latencies, channel 1 pong latencies.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [63:0] count_reg;
      logic [63:0] sum_reg;
      logic [31:0] min_reg;
      logic [31:0] max_reg;
      logic        valid;

      assign valid = done && !clear && (sample[gi] != LOST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
          sum_reg   <= '0;
          min_reg   <= '1;
          max_reg   <= '0;
        end else if (clear) begin
          count_reg <= '0;
          sum_reg   <= '0;
          min_reg   <= '1;
          max_reg   <= '0;
        end else if (valid) begin
          count_reg <= count_reg + 64'd1;
          sum_reg   <= sum_reg + {32'd0, sample[gi]};
          if (sample[gi] < min_reg) begin
            min_reg <= sample[gi];
          end
          if (sample[gi] > max_reg) begin
            max_reg <= sample[gi];
          end
        end
      end
    end
  endgenerate

  assign ping_count     = g_stat[0].count_reg;
  assign ping_sum       = g_stat[0].sum_reg;
  assign ping_min       = g_stat[0].min_reg;
  assign ping_max       = g_stat[0].max_reg;
  assign pong_count     = g_stat[1].count_reg;
  assign pong_sum       = g_stat[1].sum_reg;
  assign pong_min       = g_stat[1].min_reg;
  assign pong_max       = g_stat[1].max_reg;
  assign rd_valid       = !empty;
  assign rd_data        = rd_data_reg;
  assign fifo_level     = level;
  assign fifo_overflows = ovf_reg;

endmodule

// File: tb/tb_eth_measurer_stats.sv
// Scoreboard bench for eth_measurer_stats: records queued at done, compared when popped.
module tb_eth_measurer_stats;

  localparam int DEPTH = 16;
`ifdef ETH_MEASURER_STATS_TIMESTAMP_EN
  localparam int RW = 128;
`else
  localparam int RW = 64;
`endif
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [31:0] LOST = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          done;
  logic [31:0]   ping_time;
  logic [31:0]   pong_time;
  logic          rd_en;
  logic          rd_valid;
  logic [RW-1:0] rd_data;
  logic [LW-1:0] fifo_level;
  logic [31:0]   fifo_overflows;
  logic [63:0]   ping_count;
  logic [31:0]   ping_min;
  logic [31:0]   ping_max;
  logic [63:0]   ping_sum;
  logic [63:0]   pong_count;
  logic [31:0]   pong_min;
  logic [31:0]   pong_max;
  logic [63:0]   pong_sum;

  eth_measurer_stats #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .done(done),
    .ping_time(ping_time), .pong_time(pong_time), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level),
    .fifo_overflows(fifo_overflows),
    .ping_count(ping_count), .ping_min(ping_min), .ping_max(ping_max), .ping_sum(ping_sum),
    .pong_count(pong_count), .pong_min(pong_min), .pong_max(pong_max), .pong_sum(pong_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [RW-1:0] exp_q [$];
  logic [63:0]   m_cnt [2];
  logic [63:0]   m_sum [2];
  logic [31:0]   m_min [2];
  logic [31:0]   m_max [2];
  logic [31:0]   m_ovf;
  logic [63:0]   m_ts;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 64'd0;
      m_sum[i] = 64'd0;
      m_min[i] = LOST;
      m_max[i] = 32'd0;
    end
    m_ovf = 32'd0;
    exp_q.delete();
  endtask

  task automatic model_sample(input int ch, input logic [31:0] t);
    if (t != LOST) begin
      m_cnt[ch] = m_cnt[ch] + 64'd1;
      m_sum[ch] = m_sum[ch] + {32'd0, t};
      if (t < m_min[ch]) m_min[ch] = t;
      if (t > m_max[ch]) m_max[ch] = t;
    end
  endtask

  task automatic check_stats(input string tag);
    check_value({tag, "_ping_count"}, ping_count, m_cnt[0]);
    check_value({tag, "_ping_sum"},   ping_sum,   m_sum[0]);
    check_value({tag, "_ping_min"},   ping_min,   m_min[0]);
    check_value({tag, "_ping_max"},   ping_max,   m_max[0]);
    check_value({tag, "_pong_count"}, pong_count, m_cnt[1]);
    check_value({tag, "_pong_sum"},   pong_sum,   m_sum[1]);
    check_value({tag, "_pong_min"},   pong_min,   m_min[1]);
    check_value({tag, "_pong_max"},   pong_max,   m_max[1]);
    check_value({tag, "_overflows"},  fifo_overflows, m_ovf);
  endtask

  // One clock cycle with the inputs currently driven; model updated from pre-edge state.
  task automatic tick();
    logic [RW-1:0] rec;
    logic [RW-1:0] popped;
    bit            pop;
    pop = rd_en && (exp_q.size() > 0) && !clear;
`ifdef ETH_MEASURER_STATS_TIMESTAMP_EN
    rec = {m_ts, ping_time, pong_time};
`else
    rec = {ping_time, pong_time};
`endif
    if (clear) begin
      model_clear();
    end else begin
      if (pop) begin
        check_value("pop", rd_data, exp_q[0]);
        popped = exp_q.pop_front();
        $display("pop  rec=%0h", popped);
      end
      if (done) begin
        model_sample(0, ping_time);
        model_sample(1, pong_time);
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(rec);
          $display("push rec=%0h", rec);
        end else begin
          if (m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 32'd1;
          $display("drop rec=%0h", rec);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) m_ts = m_ts + 64'd1;
    check_value("level", fifo_level, exp_q.size());
    check_value("valid", rd_valid, exp_q.size() != 0);
    if (exp_q.size() > 0) check_value("head", rd_data, exp_q[0]);
  endtask

  task automatic cyc(input bit d, input logic [31:0] p, input logic [31:0] q, input bit r, input bit c);
    done = d; ping_time = p; pong_time = q; rd_en = r; clear = c;
    tick();
    done = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
      cyc(0, 0, 0, 1, 0);
      guard++;
    end
    check_value({tag, "_drained"}, fifo_level, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_rd_valid"}, rd_valid, 0);
    check_value({tag, "_rd_data"}, rd_data, 0);
    check_value({tag, "_level"}, fifo_level, 0);
    check_stats(tag);
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] q;
    clear = 0; done = 0; rd_en = 0; ping_time = 0; pong_time = 0;
    m_ts = 64'd0;
    model_clear();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First sample visible next cycle.
    cyc(1, 100, 200, 0, 0);
    check_value("first_rec", rd_data[63:0], 64'h0000_0064_0000_00C8);
    check_value("first_ping_min", ping_min, 100);
    check_stats("first");

    // Lost pong only touches ping statistics.
    cyc(1, 50, LOST, 0, 0);
    check_value("second_ping_sum", ping_sum, 150);
    check_stats("second");

    // Fully lost sample: statistics unchanged but record queued.
    cyc(1, LOST, LOST, 0, 0);
    check_stats("lost");
    drain("d1");

    // Empty FIFO: rd_en alongside push is ignored.
    cyc(1, 5, 6, 1, 0);
    check_value("empty_push_pop_level", fifo_level, 1);
    drain("d2");

    // Overfill by three.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH + 3; i++) cyc(1, 32'(1000 + i * 7), 32'(3000 - i * 5), 0, 0);
    check_value("ovf_level", fifo_level, DEPTH);
    check_value("ovf_count", fifo_overflows, 3);
    check_stats("ovf");
    drain("d3");

    // Full with simultaneous pop, then clear beating done.
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'(20 + i), 32'(40 + i), 0, 0);
    cyc(1, 7, 8, 1, 0);
    check_value("full_pop_level", fifo_level, DEPTH);
    check_stats("full_pop");
    cyc(1, 9, 9, 0, 1);
    check_value("clr_level", fifo_level, 0);
    check_value("clr_ping_count", ping_count, 0);
    check_stats("clr");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 7) == 0) ? LOST : 32'($urandom_range(1, 100000));
      q = ($urandom_range(0, 7) == 0) ? LOST : 32'($urandom_range(1, 100000));
      cyc($urandom_range(0, 1) == 1, p, q, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end
    check_stats("rand");

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) cyc(1, 32'(11 + i), 32'(22 + i), 0, 0);
    rst_n = 1'b0;
    model_clear();
    m_ts = 64'd0;
    #2 check_reset_outputs("async_rst");
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 300, 400, 0, 0);
    cyc(1, 301, 401, 0, 0);
    check_stats("post_rst");
    drain("d4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
